// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush sequencer with post-flush holdoff
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.

`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif

module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req_if,
  input  logic             stall_req_id,
  input  logic             stall_req_ex,
  input  logic             stall_req_mem,
  input  logic             exc_valid,
  input  logic             exc_eret,
  input  logic [`ADDR_BUS] cp0_epc_in,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [`ADDR_BUS] flush_pc,
  output logic             ctrl_busy,
  output logic [31:0]      perf_stall_cycles,
  output logic [15:0]      perf_flush_count
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [5:0] stall_run, stall_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    stall_run = 6'b000000;
    if (stall_req_mem)     stall_run = 6'b011111;
    else if (stall_req_ex) stall_run = 6'b001111;
    else if (stall_req_id) stall_run = 6'b000111;
    else if (stall_req_if) stall_run = 6'b000011;

    // Requests from ID/EX come from flushed bubbles during the holdoff window
    stall_hold = 6'b000000;
    if (stall_req_mem)     stall_hold = 6'b011111;
    else if (stall_req_if) stall_hold = 6'b000011;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 6'b000000;
    flush      = 1'b0;
    flush_pc   = '0;
    ctrl_busy  = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          if (exc_valid && !stall_req_mem) begin
            flush      = 1'b1;
            flush_pc   = exc_eret ? cp0_epc_in : EXC_VECTOR;
            cnt_next   = 4'(HOLD_CYCLES - 1);
            state_next = HOLD;
          end else begin
            stall = stall_run;
          end
        end
        HOLD: begin
          ctrl_busy = 1'b1;
          stall     = stall_hold;
          // Fetch stalls freeze the counter so the refill window is not consumed
          if (!stall_req_if) begin
            if (cnt == 4'd0) state_next = RUN;
            else             cnt_next   = cnt - 4'd1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall != 6'b000000 && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != '1)              flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt;
  assign perf_flush_count  = flush_cnt;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl

module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        exc_valid, exc_eret;
  logic [31:0] cp0_epc_in;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ctrl_busy;
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;

  int checks   = 0;
  int failures = 0;

  pipeline_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stall_req_if      (stall_req_if),
    .stall_req_id      (stall_req_id),
    .stall_req_ex      (stall_req_ex),
    .stall_req_mem     (stall_req_mem),
    .exc_valid         (exc_valid),
    .exc_eret          (exc_eret),
    .cp0_epc_in        (cp0_epc_in),
    .stall             (stall),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .ctrl_busy         (ctrl_busy),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic i_if, input logic i_id, input logic i_ex,
                        input logic i_mem, input logic ev, input logic er);
    stall_req_if  = i_if;
    stall_req_id  = i_id;
    stall_req_ex  = i_ex;
    stall_req_mem = i_mem;
    exc_valid     = ev;
    exc_eret      = er;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] st, input logic fl,
                            input logic [31:0] pc, input logic busy);
    check({tag, ".stall"}, 32'(stall), 32'(st));
    check({tag, ".flush"}, 32'(flush), 32'(fl));
    check({tag, ".flush_pc"}, flush_pc, pc);
    check({tag, ".busy"}, 32'(ctrl_busy), 32'(busy));
  endtask

  initial begin
    rst        = 1'b0;
    cp0_epc_in = 32'hBFC00104;
    set_in(1, 1, 1, 0, 1, 1);
    expect_out("reset_forced", 6'b000000, 0, 32'h0, 0);
    check("reset_perf_stall", perf_stall_cycles, 32'd0);
    check("reset_perf_flush", 32'(perf_flush_count), 32'd0);
    tick();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    expect_out("idle", 6'b000000, 0, 32'h0, 0);

    // Stall priority
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 1, 0, 0);
      expect_out($sformatf("prio_mem_id%0d", i), 6'b011111, 0, 32'h0, 0);
      tick();
    end
    set_in(0, 1, 0, 0, 0, 0);
    expect_out("prio_id", 6'b000111, 0, 32'h0, 0);
    tick();
    set_in(1, 0, 1, 0, 0, 0);
    expect_out("prio_ex_if", 6'b001111, 0, 32'h0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0);
    expect_out("prio_if", 6'b000011, 0, 32'h0, 0);
    tick();

    // Exception into EXC_VECTOR, then two HOLD cycles
    set_in(0, 0, 0, 0, 1, 0);
    expect_out("exc", 6'b000000, 1, 32'hBFC00380, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    expect_out("exc_hold1", 6'b000000, 0, 32'h0, 1);
    tick();
    expect_out("exc_hold2", 6'b000000, 0, 32'h0, 1);
    tick();
    expect_out("exc_run", 6'b000000, 0, 32'h0, 0);

    // ERET with concurrent ID stall: exception wins; HOLD ignores ID/EX but honours MEM
    set_in(0, 1, 0, 0, 1, 1);
    expect_out("eret", 6'b000000, 1, 32'hBFC00104, 0);
    tick();
    set_in(0, 1, 1, 0, 1, 0);
    expect_out("hold_ignore", 6'b000000, 0, 32'h0, 1);
    tick();
    set_in(0, 0, 0, 1, 0, 0);
    expect_out("hold_mem", 6'b011111, 0, 32'h0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    expect_out("eret_run", 6'b000000, 0, 32'h0, 0);

    // Deferred exception behind a MEM stall
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 1, 1, 0);
      expect_out($sformatf("defer%0d", i), 6'b011111, 0, 32'h0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 1, 0);
    expect_out("defer_take", 6'b000000, 1, 32'hBFC00380, 0);
    tick();

    // Holdoff: exc_valid still high during the HOLD window yields no further flush
    expect_out("holdoff1", 6'b000000, 0, 32'h0, 1);
    tick();
    expect_out("holdoff2", 6'b000000, 0, 32'h0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    expect_out("holdoff_run", 6'b000000, 0, 32'h0, 0);

    // Fetch stalls freeze the hold counter: busy stretches to 5 cycles
    set_in(0, 0, 0, 0, 1, 0);
    expect_out("freeze_exc", 6'b000000, 1, 32'hBFC00380, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0, 0, 0);
      expect_out($sformatf("freeze_if%0d", i), 6'b000011, 0, 32'h0, 1);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    expect_out("freeze_h4", 6'b000000, 0, 32'h0, 1);
    tick();
    expect_out("freeze_h5", 6'b000000, 0, 32'h0, 1);
    tick();
    expect_out("freeze_run", 6'b000000, 0, 32'h0, 0);

    // Reset mid-HOLD
    set_in(0, 0, 0, 0, 1, 0);
    expect_out("rst_exc", 6'b000000, 1, 32'hBFC00380, 0);
    tick();
    rst = 1'b0;
    set_in(1, 1, 0, 1, 1, 0);
    expect_out("rst_mid_hold", 6'b000000, 0, 32'h0, 0);
    check("rst_perf_stall", perf_stall_cycles, 32'd0);
    check("rst_perf_flush", 32'(perf_flush_count), 32'd0);
    tick();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    expect_out("rst_release", 6'b000000, 0, 32'h0, 0);

    // Post-reset exception plus one fetch stall in HOLD exercises the counters
    set_in(0, 0, 0, 0, 1, 0);
    expect_out("post_rst_exc", 6'b000000, 1, 32'hBFC00380, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0);
    expect_out("post_rst_hold_if", 6'b000011, 0, 32'h0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
    check("perf_flush", 32'(perf_flush_count), 32'd1);
    check("perf_stall", perf_stall_cycles, 32'd1);
`else
    check("perf_flush_tied", 32'(perf_flush_count), 32'd0);
    check("perf_stall_tied", perf_stall_cycles, 32'd0);
`endif
    tick();
    tick();
    expect_out("final_run", 6'b000000, 0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
